feature_frame_loader: RTL and testbench

FEATURE_FRAME_LOADER -- requirements
Module: feature_frame_loader

---
 rtl/mlp_if_pkg.sv | 16 +
 rtl/feature_frame_loader.sv | 142 ++++++++++++++
 tb/tb_feature_frame_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_if_pkg.sv
// mlp_if_pkg
// Shared definitions for the feature loader and the classifier that sits
// behind it: default frame geometry and the loader's state encoding.
package mlp_if_pkg;

  localparam int NUM_FEAT_DEF = 6;  // features per frame
  localparam int FEAT_W_DEF   = 4;  // bits per feature
  localparam int CLS_W_DEF    = 2;  // class index width

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,  // accepting feature beats
    ST_SETTLE = 2'd1,  // frame complete, classifier output settling
    ST_RESULT = 2'd2   // class captured, waiting for the consumer
  } state_t;

endpackage

// File: rtl/feature_frame_loader.sv
// feature_frame_loader
// Collects a frame of NUM_FEAT feature beats into a packed vector that feeds
// a combinational classifier, waits SETTLE_CYC cycles for that classifier to
// settle, captures its class index and offers it as a result.
//
// Ports
//   clk, rst_n                : clock (rising edge), async active-low reset
//   feat_valid/feat_ready     : feature beat handshake
//   feat_data, feat_last      : feature value and end-of-frame marker
//   cls_inp                   : packed features to the classifier (beat 0 in LSBs)
//   cls_out                   : class index from the classifier
//   res_valid/res_ready       : result handshake
//   res_class                 : captured class index
//   frame_err                 : one-cycle pulse when a frame is malformed
module feature_frame_loader
  import mlp_if_pkg::*;
#(
  parameter int NUM_FEAT   = NUM_FEAT_DEF,
  parameter int FEAT_W     = FEAT_W_DEF,
  parameter int CLS_W      = CLS_W_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  input  logic [FEAT_W-1:0]          feat_data,
  input  logic                       feat_last,
  output logic [NUM_FEAT*FEAT_W-1:0] cls_inp,
  input  logic [CLS_W-1:0]           cls_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [CLS_W-1:0]           res_class,
  output logic                       frame_err
);

  localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_FEAT - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC);

  state_t             state_reg;
  logic [CNT_W-1:0]   beat_cnt_reg;
  logic [3:0]         settle_cnt_reg;
  logic [CLS_W-1:0]   res_class_reg;
  logic               res_valid_reg;
  logic               feat_ready_reg;
  logic               frame_err_reg;

  logic beat_xfer;
  logic beat_ok;
  logic beat_write;

  // A beat is well formed when feat_last agrees with "this is the final slot".
  // Either disagreement (early last, or missing last) is a malformed frame.
  always_comb begin
    beat_xfer  = (state_reg == ST_LOAD) && feat_valid && feat_ready_reg;
    beat_ok    = (feat_last == (beat_cnt_reg == LAST_IDX));
    beat_write = beat_xfer && beat_ok;
  end

  // One register per feature slot; only the slot addressed by the beat
  // counter is written, so an aborted frame leaves the upper slots stale.
  generate
    for (genvar gi = 0; gi < NUM_FEAT; gi++) begin : g_feat
      logic [FEAT_W-1:0] feat_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          feat_reg <= '0;
        end else if (beat_write && (beat_cnt_reg == CNT_W'(gi))) begin
          feat_reg <= feat_data;
        end
      end
      assign cls_inp[gi*FEAT_W +: FEAT_W] = feat_reg;
    end
  endgenerate

  // Control FSM. feat_ready/res_valid are registered and track the state,
  // so neither depends combinationally on the handshake inputs. feat_ready
  // stays low through reset and comes up on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_LOAD;
      beat_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      res_class_reg  <= '0;
      res_valid_reg  <= 1'b0;
      feat_ready_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          feat_ready_reg <= 1'b1;
          if (beat_xfer) begin
            if (!beat_ok) begin
              frame_err_reg <= 1'b1;
              beat_cnt_reg  <= '0;
            end else if (feat_last) begin
              beat_cnt_reg   <= '0;
              settle_cnt_reg <= '0;
              feat_ready_reg <= 1'b0;
              state_reg      <= ST_SETTLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        // The counter starts at 0 on entry and capture happens when it
        // reaches SETTLE_CYC, so res_valid rises SETTLE_CYC+1 edges after
        // the edge that accepted the last beat.
        ST_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            res_class_reg <= cls_out;
            res_valid_reg <= 1'b1;
            state_reg     <= ST_RESULT;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_reg  <= 1'b0;
            feat_ready_reg <= 1'b1;
            state_reg      <= ST_LOAD;
          end
        end
        default: begin
          res_valid_reg  <= 1'b0;
          feat_ready_reg <= 1'b0;
          beat_cnt_reg   <= '0;
          state_reg      <= ST_LOAD;
        end
      endcase
    end
  end

  assign feat_ready = feat_ready_reg;
  assign res_valid  = res_valid_reg;
  assign res_class  = res_class_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_feature_frame_loader.sv
// tb_feature_frame_loader
// Self-checking bench for feature_frame_loader: directed frame, malformed
// frames, result back-pressure, asynchronous reset, and a randomized stream
// of frames compared against a frame-level reference model.
module tb_feature_frame_loader;
  import mlp_if_pkg::*;

  localparam int NF = 6;
  localparam int FW = 4;
  localparam int CW = 2;
  localparam int SC = 2;
  localparam int VW = NF * FW;
  localparam int NUM_RAND = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          feat_valid = 1'b0;
  logic          feat_ready;
  logic [FW-1:0] feat_data = '0;
  logic          feat_last = 1'b0;
  logic [VW-1:0] cls_inp;
  logic [CW-1:0] cls_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_class;
  logic          frame_err;

  logic          stub_mode = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            err_pulses = 0;

  logic [CW-1:0] got_class_q[$];
  logic [VW-1:0] got_inp_q[$];
  logic [CW-1:0] exp_class_q[$];
  logic [VW-1:0] exp_inp_q[$];

  feature_frame_loader #(
    .NUM_FEAT(NF), .FEAT_W(FW), .CLS_W(CW), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .feat_last(feat_last),
    .cls_inp(cls_inp), .cls_out(cls_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Classifier stub: constant 2'b10, or sum of features modulo 4.
  function automatic logic [CW-1:0] stub_class(input logic [VW-1:0] v);
    int s = 0;
    for (int i = 0; i < NF; i++) s += int'(v[i*FW +: FW]);
    return CW'(s % 4);
  endfunction

  assign cls_out = stub_mode ? stub_class(cls_inp) : 2'b10;

  always @(negedge clk) if (frame_err) err_pulses++;

  always @(posedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      got_class_q.push_back(res_class);
      got_inp_q.push_back(cls_inp);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input logic [FW-1:0] d, input logic last);
    int w = 0;
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = last;
    while (!feat_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("beat_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    $display("beat data=%0h last=%0b", d, last);
  endtask

  task automatic idle(input int n);
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [VW-1:0] v);
    for (int i = 0; i < NF; i++) send_beat(v[i*FW +: FW], (i == NF - 1));
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  // Counts edges after the accepting edge until res_valid is seen.
  task automatic wait_result(input logic [VW-1:0] exp_inp, input logic [CW-1:0] exp_cls);
    int n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("res_latency", 64'(n), 64'(SC + 1));
    check("res_class", 64'(res_class), 64'(exp_cls));
    check("cls_inp", 64'(cls_inp), 64'(exp_inp));
    check("ready_in_result", 64'(feat_ready), 64'd0);
    @(negedge clk);
    $display("result class=%0h inp=%0h latency=%0d", res_class, cls_inp, n);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_after_hs", 64'(res_valid), 64'd0);
    check("ready_after_hs", 64'(feat_ready), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(feat_ready), 64'd0);
    check({tag, "_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_class"}, 64'(res_class), 64'd0);
    check({tag, "_inp"}, 64'(cls_inp), 64'd0);
    check({tag, "_err"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic [VW-1:0] v;
    int s;
    int k;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    check("ready_before_edge", 64'(feat_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 64'(feat_ready), 64'd1);
    @(negedge clk);

    // Directed frame 1..6
    send_frame(24'h654321);
    wait_result(24'h654321, 2'b10);
    consume();

    // Early last on beat 3
    e0 = err_pulses;
    send_beat(4'hA, 1'b0);
    send_beat(4'hB, 1'b0);
    send_beat(4'hC, 1'b1);
    idle(6);
    check("early_last_err", 64'(err_pulses - e0), 64'd1);
    check("early_last_ready", 64'(feat_ready), 64'd1);
    check("early_last_valid", 64'(res_valid), 64'd0);
    check("early_last_inp", 64'(cls_inp), 64'h6543BA);
    send_frame(24'hFEDCBA);
    wait_result(24'hFEDCBA, 2'b10);
    consume();

    // Missing last on beat 6
    e0 = err_pulses;
    for (int i = 1; i <= NF; i++) send_beat(FW'(i), 1'b0);
    idle(6);
    check("missing_last_err", 64'(err_pulses - e0), 64'd1);
    check("missing_last_valid", 64'(res_valid), 64'd0);
    check("missing_last_inp", 64'(cls_inp), 64'hF54321);
    send_frame(24'h2468AC);
    wait_result(24'h2468AC, 2'b10);
    consume();

    // Back-pressure on the result
    send_frame(24'h9ABCDE);
    wait_result(24'h9ABCDE, 2'b10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_class", 64'(res_class), 64'd2);
      check("hold_inp", 64'(cls_inp), 64'h9ABCDE);
      check("hold_ready", 64'(feat_ready), 64'd0);
    end
    consume();

    // Async reset after beat 4
    for (int i = 1; i <= 4; i++) send_beat(FW'(i + 8), 1'b0);
    feat_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_midframe");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(24'h777777);
    wait_result(24'h777777, 2'b10);
    consume();

    // Async reset during SETTLE
    send_frame(24'h111111);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_settle");
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("settle_discard_valid", 64'(res_valid), 64'd0);
    send_frame(24'h3C5A96);
    wait_result(24'h3C5A96, 2'b10);
    consume();

    // Random stream, res_ready held high
    stub_mode = 1'b1;
    got_class_q.delete();
    got_inp_q.delete();
    res_ready = 1'b1;
    for (int f = 0; f < NUM_RAND; f++) begin
      s = 0;
      for (int i = 0; i < NF; i++) begin
        v[i*FW +: FW] = FW'($urandom_range(0, (1 << FW) - 1));
        s += int'(v[i*FW +: FW]);
      end
      exp_inp_q.push_back(v);
      exp_class_q.push_back(CW'(s % 4));
      for (int i = 0; i < NF; i++) begin
        k = $urandom_range(0, 2);
        if (k != 0) idle(k);
        send_beat(v[i*FW +: FW], (i == NF - 1));
      end
    end
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    k = 0;
    while (got_class_q.size() < NUM_RAND && k < 500) begin
      @(negedge clk);
      k++;
    end
    idle(10);
    check("rand_count", 64'(got_class_q.size()), 64'(NUM_RAND));
    for (int f = 0; f < NUM_RAND && f < got_class_q.size(); f++) begin
      check("rand_class", 64'(got_class_q[f]), 64'(exp_class_q[f]));
      check("rand_inp", 64'(got_inp_q[f]), 64'(exp_inp_q[f]));
      $display("frame %0d class=%0h exp=%0h", f, got_class_q[f], exp_class_q[f]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
